shift_seq_rgst: RTL
===================

# shift_seq_rgst

Parametrised multi-mode sequential shift register for the ALU datapath. It holds a `width`-bit operand that is either parallel-loaded or shifted by a multi-bit amount. The shift runs one bit position per clock, under a start/busy/done handshake, in logical-left, logical-right, arithmetic-right or (optionally) rotate-right mode. It replaces single-step shift registers wherever the control unit needs shift counts greater than one without sequencing each step itself.

## Interface

Parameters:
- `width` — default 8 — register width in bits; legal range ≥ 2.
- `amt_w` — localparam, not overridable — equals `$clog2(width)+1`, the width of the shift amount.

Ports:
- `clk` — in — 1 — single clock; all state updates on its rising edge.
- `reset` — in — 1 — asynchronous, active-high; clears all state immediately.
- `load_enable` — in — 1 — parallel load of `data_in`; accepted in IDLE only.
- `data_in` — in — `width` — parallel load value.
- `start` — in — 1 — begin a shift operation; accepted in IDLE only.
- `mode` — in — 2 — shift mode, sampled with `start`:
  - `00` LSL
  - `01` LSR
  - `10` ASR
  - `11` ROR
- `amount` — in — `amt_w` — number of single-bit steps, sampled with `start`; range 0 … 2^amt_w−1.
- `busy` — out — 1 — high whenever the FSM is not in IDLE.
- `done` — out — 1 — one-cycle pulse when the operation completes.
- `carry_out` — out — 1 — last bit shifted or rotated out.
- `zero` — out — 1 — combinational; high when `data_out == 0`.
- `data_out` — out — `width` — register contents.

## Operation

- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:**
  - If `load_enable` is high: `data_out <= data_in` and `carry_out <= 0`. Any `start` in the same cycle is ignored; load has priority.
  - Else if `start` is high: latch `mode`, load the step counter with `amount`, clear `carry_out`. Next state is SHIFT if `amount != 0`, otherwise DONE.
- **SHIFT:** one step per edge, then decrement the counter. Leave for DONE on the edge that performs the final step (counter == 1). Step rules:
  - LSL: `{data_out[width-2:0],1'b0}`; `carry_out <= data_out[width-1]`.
  - LSR: `{1'b0,data_out[width-1:1]}`; `carry_out <= data_out[0]`.
  - ASR: `{data_out[width-1],data_out[width-1:1]}`; `carry_out <= data_out[0]`.
  - ROR: `{data_out[0],data_out[width-1:1]}`; `carry_out <= data_out[0]`.
- **DONE:** `done` = 1 for exactly this cycle; the register holds its value; next state is IDLE.
- `load_enable` and `start` are ignored in SHIFT and DONE; there is no queuing.
- Amounts ≥ `width` are executed literally, with no clamping:
  - LSL/LSR give all zeros.
  - ASR gives all sign bits.
  - ROR gives the value rotated by `amount mod width`.
- A mid-operation change of `mode` or `amount` has no effect.

## Timing

- Reset values: `data_out = 0`, `carry_out = 0`, `busy = 0`, `done = 0`, FSM in IDLE, counter 0. `zero = 1` during reset.
- Reset asserted mid-operation aborts the operation asynchronously with the values above. No `done` pulse is produced.
- Load latency: `data_out` is valid one edge after `load_enable` is sampled.
- Start sampled at edge t:
  - `busy` rises after t.
  - Shifts occur at edges t+1 … t+`amount`.
  - `done` is high during the cycle after edge t+`amount`.
  - `busy` falls after edge t+`amount`+1.
- `amount == 0`: `done` is high during the cycle after t; `data_out` is unchanged; `carry_out` is 0.
- Start-to-done latency is `amount`+1 cycles (minimum 1). A new `start` is accepted in the cycle after `done`.

## Configuration

- `SHIFT_SEQ_ROTATE_EN` defined: mode `11` performs ROR as specified above.
- Not defined:
  - No rotate logic is compiled in.
  - Mode `11` is a no-op: go directly to DONE, one-cycle latency as for `amount == 0`.
  - `data_out` is unchanged and `carry_out` is cleared.

## Test plan

All scenarios use `width` = 8.

- Load 0xB2, then LSL with `amount` 2 → `data_out` 0xC8, `carry_out` 0, `done` 3 cycles after start, `busy` high for 3 cycles.
- Load 0xB2, then ASR with `amount` 3 → 0xF6, `carry_out` 0. Load 0x72, then ASR with `amount` 1 → 0x39, `carry_out` 0.
- Load 0xFF, then LSR with `amount` 9 → 0x00, `zero` 1, `carry_out` 0, `done` 10 cycles after start.
- With the macro: load 0xB2, ROR with `amount` 4 → 0x2B, `carry_out` 0. Without the macro: same stimulus → 0xB2, `done` after 1 cycle.
- `load_enable` and `start` together in IDLE → load taken, no `busy`. `start` with `amount` 0 → `done` next cycle, data unchanged. `start` while busy → ignored.
- LSL with `amount` 7 on 0x01, `reset` pulsed after 3 shifts → all outputs return to reset values at once, no `done`. A subsequent load 0x5A works normally.

Source files
------------

// File: rtl/shift_seq_rgst_if.sv
// Handshake and data bundle for shift_seq_rgst.
// The master drives load/start/operands; the slave returns status and register contents.
interface shift_seq_rgst_if #(
    parameter int width = 8
);
    localparam int amt_w = $clog2(width) + 1;

    logic             load_enable;
    logic [width-1:0] data_in;
    logic             start;
    logic [1:0]       mode;
    logic [amt_w-1:0] amount;
    logic             busy;
    logic             done;
    logic             carry_out;
    logic             zero;
    logic [width-1:0] data_out;

    modport master (
        output load_enable, data_in, start, mode, amount,
        input  busy, done, carry_out, zero, data_out
    );

    modport slave (
        input  load_enable, data_in, start, mode, amount,
        output busy, done, carry_out, zero, data_out
    );
endinterface

// File: rtl/shift_seq_rgst.sv
// Multi-mode sequential shift register: parallel load, or LSL/LSR/ASR/ROR by a multi-bit amount, one bit per clock.
// Define SHIFT_SEQ_ROTATE_EN to compile in rotate-right; otherwise mode 11 completes as a one-cycle no-op.
module shift_seq_rgst #(
    parameter int width = 8
) (
    input logic             clk,
    input logic             reset,
    shift_seq_rgst_if.slave bus
);
    localparam int amt_w = $clog2(width) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [amt_w-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             skip_shift;

    // Zero amounts, and rotate when it is not built in, finish without entering SHIFT.
    always_comb begin
        skip_shift = (bus.amount == '0);
`ifndef SHIFT_SEQ_ROTATE_EN
        if (bus.mode == 2'b11) skip_shift = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.load_enable) begin
                    data_d  = bus.data_in;
                    carry_d = 1'b0;
                end else if (bus.start) begin
                    mode_d  = bus.mode;
                    cnt_d   = bus.amount;
                    carry_d = 1'b0;
                    state_d = skip_shift ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                case (mode_q)
                    2'b00: begin
                        data_d  = {data_q[width-2:0], 1'b0};
                        carry_d = data_q[width-1];
                    end
                    2'b01: begin
                        data_d  = {1'b0, data_q[width-1:1]};
                        carry_d = data_q[0];
                    end
                    2'b10: begin
                        data_d  = {data_q[width-1], data_q[width-1:1]};
                        carry_d = data_q[0];
                    end
`ifdef SHIFT_SEQ_ROTATE_EN
                    2'b11: begin
                        data_d  = {data_q[0], data_q[width-1:1]};
                        carry_d = data_q[0];
                    end
`endif
                    default: begin
                        data_d  = data_q;
                        carry_d = carry_q;
                    end
                endcase
                cnt_d = cnt_q - amt_w'(1);
                if (cnt_q == amt_w'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.carry_out = carry_q;
    assign bus.zero      = (data_q == '0);
    assign bus.data_out  = data_q;
endmodule
